elevator_call_scheduler: RTL and testbench



---
 rtl/elevator_call_scheduler_if.sv | 11 +
 rtl/elevator_call_scheduler.sv | 162 ++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/elevator_call_scheduler_if.sv
// Move-command channel between the call scheduler and the stepper-motor drive.
interface elevator_call_scheduler_if;
    logic        mv_valid;
    logic        mv_ready;
    logic        mv_dir;
    logic [15:0] mv_steps;
    logic        mv_done;

    modport master (output mv_valid, mv_dir, mv_steps, input mv_ready, mv_done);
    modport slave  (input mv_valid, mv_dir, mv_steps, output mv_ready, mv_done);
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches floor calls, issues one move per call to the motor drive,
// then holds the door open for a dwell interval before serving the next call.
module elevator_call_scheduler #(
    parameter int unsigned NUM_FLOORS      = 3,
    parameter int unsigned STEPS_PER_FLOOR = 5688,
    parameter int unsigned DWELL_CYCLES    = 10000000,
    localparam int unsigned FLOOR_W        = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_p,
    input  logic [NUM_FLOORS-1:0]     call_pulse,
    elevator_call_scheduler_if.master mv,
    output logic [NUM_FLOORS-1:0]     pending,
    output logic [FLOOR_W-1:0]        cur_floor,
    output logic                      door_open,
    output logic                      busy
);

    localparam int unsigned CNT_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned STEPS_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, MOVE, DWELL} state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    cur_q, cur_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  last_dir_q, last_dir_d;
    logic                  valid_q, valid_d;
    logic                  dir_q, dir_d;
    logic [STEPS_W-1:0]    steps_q, steps_d;
    logic                  door_q, door_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  has_above, has_below, pick_up;
    logic [FLOOR_W-1:0]    near_above, near_below, sel_target, sel_diff;
    logic [NUM_FLOORS-1:0] latched, cur_mask;

    // Nearest pending floor above and below the current floor, then SCAN preference
    always_comb begin
        has_above  = 1'b0;
        has_below  = 1'b0;
        near_above = '0;
        near_below = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_W'(i) > cur_q)) begin
                has_above  = 1'b1;
                near_above = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (FLOOR_W'(i) < cur_q)) begin
                has_below  = 1'b1;
                near_below = FLOOR_W'(i);
            end
        end
        pick_up    = last_dir_q ? (has_above && !has_below) : (has_above || !has_below);
        sel_target = pick_up ? near_above : near_below;
        sel_diff   = pick_up ? (near_above - cur_q) : (cur_q - near_below);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            cur_q      <= '0;
            target_q   <= '0;
            last_dir_q <= 1'b0;
            valid_q    <= 1'b0;
            dir_q      <= 1'b0;
            steps_q    <= '0;
            door_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            cur_q      <= cur_d;
            target_q   <= target_d;
            last_dir_q <= last_dir_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
            steps_q    <= steps_d;
            door_q     <= door_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        target_d   = target_q;
        last_dir_d = last_dir_q;
        valid_d    = valid_q;
        dir_d      = dir_q;
        steps_d    = steps_q;
        door_d     = door_q;
        cnt_d      = cnt_q;
        latched    = pending_q | call_pulse;
        cur_mask   = NUM_FLOORS'(1) << cur_q;
        pending_d  = latched;

        unique case (state_q)
            IDLE: begin
                // A call (or stale latch) for the floor we are parked at just opens the door
                pending_d = latched & ~cur_mask;
                if (call_pulse[cur_q] || pending_q[cur_q]) begin
                    state_d = DWELL;
                    door_d  = 1'b1;
                    cnt_d   = CNT_W'(DWELL_CYCLES - 1);
                end else if (pending_q != '0) begin
                    state_d  = ISSUE;
                    target_d = sel_target;
                    dir_d    = !pick_up;
                    steps_d  = STEPS_W'(sel_diff) * STEPS_W'(STEPS_PER_FLOOR);
                    valid_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (mv.mv_ready) begin
                    state_d    = MOVE;
                    valid_d    = 1'b0;
                    last_dir_d = dir_q;
                end
            end
            MOVE: begin
                if (mv.mv_done) begin
                    state_d             = DWELL;
                    cur_d               = target_q;
                    pending_d[target_q] = 1'b0;
                    door_d              = 1'b1;
                    cnt_d               = CNT_W'(DWELL_CYCLES - 1);
                end
            end
            DWELL: begin
                pending_d = latched & ~cur_mask;
                if (call_pulse[cur_q]) begin
                    cnt_d = CNT_W'(DWELL_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    door_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign mv.mv_valid = valid_q;
    assign mv.mv_dir   = dir_q;
    assign mv.mv_steps = steps_q;
    assign pending     = pending_q;
    assign cur_floor   = cur_q;
    assign door_open   = door_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: 3 floors, 8-cycle dwell, drive finishes 20 cycles after accept.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic [2:0] call_pulse = 3'b000;
    logic [2:0] pending;
    logic [1:0] cur_floor;
    logic       door_open;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    elevator_call_scheduler_if mv_if ();

    elevator_call_scheduler #(
        .NUM_FLOORS     (3),
        .STEPS_PER_FLOOR(5688),
        .DWELL_CYCLES   (8)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .call_pulse(call_pulse),
        .mv        (mv_if),
        .pending   (pending),
        .cur_floor (cur_floor),
        .door_open (door_open),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count consecutive observed cycles with the door open
    task automatic count_door(input string tag, input int exp);
        int n = 0;
        while (door_open === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk(tag, n, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            n++;
            tick();
        end
        chk(tag, busy, 0);
    endtask

    // Wait for a command, accept it, finish the move 20 cycles later
    task automatic serve(input string tag, input logic exp_dir, input logic [15:0] exp_steps,
                         input logic [1:0] exp_floor);
        int n = 0;
        mv_if.mv_ready = 1'b1;
        while (mv_if.mv_valid !== 1'b1 && n < 10) begin
            n++;
            tick();
        end
        chk({tag, "_valid"}, mv_if.mv_valid, 1);
        chk({tag, "_dir"}, mv_if.mv_dir, exp_dir);
        chk({tag, "_steps"}, mv_if.mv_steps, exp_steps);
        tick();
        chk({tag, "_valid_drop"}, mv_if.mv_valid, 0);
        repeat (19) tick();
        mv_if.mv_done = 1'b1;
        tick();
        mv_if.mv_done = 1'b0;
        chk({tag, "_floor"}, cur_floor, exp_floor);
        chk({tag, "_door"}, door_open, 1);
    endtask

    initial begin
        logic seen_valid;
        mv_if.mv_ready = 1'b0;
        mv_if.mv_done  = 1'b0;

        // Reset, then idle
        repeat (3) tick();
        reset_p = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_valid |= mv_if.mv_valid;
        end
        chk("idle_no_valid", seen_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_floor", cur_floor, 0);
        chk("rst_door", door_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dir", mv_if.mv_dir, 0);
        chk("rst_steps", mv_if.mv_steps, 0);

        // Call to floor 2 from floor 0, drive stalls 5 cycles before accepting
        call_pulse = 3'b100;
        tick();
        call_pulse = 3'b000;
        chk("t2_pending", pending, 3'b100);
        chk("t2_valid_early", mv_if.mv_valid, 0);
        tick();
        chk("t2_valid", mv_if.mv_valid, 1);
        chk("t2_dir", mv_if.mv_dir, 0);
        chk("t2_steps", mv_if.mv_steps, 11376);
        chk("t2_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_valid", mv_if.mv_valid, 1);
            chk("t3_stall_dir", mv_if.mv_dir, 0);
            chk("t3_stall_steps", mv_if.mv_steps, 11376);
        end
        mv_if.mv_ready = 1'b1;
        tick();
        chk("t3_single_xfer", mv_if.mv_valid, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            seen_valid |= mv_if.mv_valid;
        end
        chk("t3_no_revalid", seen_valid, 0);
        chk("t2_floor_before_done", cur_floor, 0);
        mv_if.mv_done = 1'b1;
        tick();
        mv_if.mv_done = 1'b0;
        chk("t2_floor", cur_floor, 2);
        chk("t2_pending_clr", pending, 0);
        count_door("t2_dwell_len", 8);
        chk("t2_idle", busy, 0);

        // Call for the current floor while idle, repeated in dwell cycle 5
        call_pulse = 3'b100;
        tick();
        call_pulse = 3'b000;
        chk("t5_door", door_open, 1);
        chk("t5_not_latched", pending, 0);
        chk("t5_no_valid", mv_if.mv_valid, 0);
        repeat (4) tick();
        chk("t5_door_c5", door_open, 1);
        call_pulse = 3'b100;
        tick();
        call_pulse = 3'b000;
        chk("t5_reopen_not_latched", pending, 0);
        count_door("t5_reopen_len", 8);
        chk("t5_idle", busy, 0);
        chk("t5_floor", cur_floor, 2);

        // Call to floor 1, reset while moving
        call_pulse = 3'b010;
        tick();
        call_pulse = 3'b000;
        tick();
        chk("t6_valid", mv_if.mv_valid, 1);
        chk("t6_dir", mv_if.mv_dir, 1);
        chk("t6_steps", mv_if.mv_steps, 5688);
        tick();
        chk("t6_moving", busy, 1);
        chk("t6_pending", pending, 3'b010);
        repeat (3) tick();
        reset_p = 1'b1;
        #1;
        chk("t6_async_pending", pending, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_floor", cur_floor, 0);
        chk("t6_async_dir", mv_if.mv_dir, 0);
        chk("t6_async_steps", mv_if.mv_steps, 0);
        #2;
        reset_p = 1'b0;
        tick();
        mv_if.mv_done = 1'b1;
        tick();
        mv_if.mv_done = 1'b0;
        chk("t6_stray_done_floor", cur_floor, 0);
        chk("t6_stray_done_busy", busy, 0);
        chk("t6_stray_done_door", door_open, 0);

        // Up to floor 1, then calls for floors 0 and 2 together
        call_pulse = 3'b010;
        tick();
        call_pulse = 3'b000;
        serve("t4_up1", 1'b0, 16'd5688, 2'd1);
        wait_idle("t4_idle1");
        call_pulse = 3'b101;
        tick();
        call_pulse = 3'b000;
        chk("t4_pending101", pending, 3'b101);
        serve("t4_to2", 1'b0, 16'd5688, 2'd2);
        chk("t4_pending001", pending, 3'b001);
        wait_idle("t4_idle2");
        serve("t4_to0", 1'b1, 16'd11376, 2'd0);
        chk("t4_pending000", pending, 3'b000);
        wait_idle("t4_idle3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
